// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with NORMAL/FWFT read modes, registered count and threshold flags.
// Optional FIFO_SYNC_WATERMARK_EN adds the peak-occupancy output.
module fifo_sync_flags #(
    parameter int    DSIZE    = 8,
    parameter int    ASIZE    = 4,
    parameter string MODE     = "NORMAL",
    parameter int    AF_LEVEL = (1 << ASIZE) - 2,
    parameter int    AE_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DSIZE-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic [DSIZE-1:0] dout,
    input  logic             rd_en,
    output logic             empty,
    output logic             almost_empty,
    output logic             underflow,
    output logic [ASIZE:0]   count
`ifdef FIFO_SYNC_WATERMARK_EN
    ,
    output logic [ASIZE:0]   peak
`endif
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam bit             FWFT    = (MODE == "FWFT");
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AF_C    = (ASIZE + 1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_C    = (ASIZE + 1)'(AE_LEVEL);

    generate
        if (MODE != "NORMAL" && MODE != "FWFT") begin : g_bad_mode
            $error("fifo_sync_flags: MODE must be \"NORMAL\" or \"FWFT\"");
        end
    endgenerate

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   rptr_inc;
    logic [ASIZE:0]   cnt_nx;
    logic             wr_acc;
    logic             rd_acc;

    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    assign rptr_inc = rptr + 1'b1;

    always_comb begin
        cnt_nx = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_nx = count + 1'b1;
            2'b01:   cnt_nx = count - 1'b1;
            default: cnt_nx = count;
        endcase
    end

    // Storage is not reset; the write is suppressed while rst or flush is active.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush && !rst)
            mem[wptr[ASIZE-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            dout         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            dout         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc)
                rptr <= rptr_inc;
            count        <= cnt_nx;
            full         <= (cnt_nx == DEPTH_C);
            almost_full  <= (cnt_nx >= AF_C);
            almost_empty <= (cnt_nx <= AE_C);
            if (wr_en && full)
                overflow <= 1'b1;
            if (rd_en && empty)
                underflow <= 1'b1;

            // In FWFT the head word stays in memory until popped, so the
            // word on dout still occupies a slot and capacity stays DEPTH.
            if (FWFT) begin
                if (empty) begin
                    if (count != '0) begin
                        dout  <= mem[rptr[ASIZE-1:0]];
                        empty <= 1'b0;
                    end
                end else if (rd_acc) begin
                    if (count > 1)
                        dout <= mem[rptr_inc[ASIZE-1:0]];
                    else
                        empty <= 1'b1;
                end
            end else begin
                empty <= (cnt_nx == '0);
                if (rd_acc)
                    dout <= mem[rptr[ASIZE-1:0]];
            end
        end
    end

`ifdef FIFO_SYNC_WATERMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= '0;
        else if (flush)
            peak <= '0;
        else if (cnt_nx > peak)
            peak <= cnt_nx;
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed scoreboard bench for fifo_sync_flags; runs the same sequence against
// a NORMAL and an FWFT instance, checking one of them per pass.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;

    logic       n_full, n_af, n_ov, n_empty, n_ae, n_uf;
    logic [7:0] n_dout;
    logic [4:0] n_count;
    logic       f_full, f_af, f_ov, f_empty, f_ae, f_uf;
    logic [7:0] f_dout;
    logic [4:0] f_count;
`ifdef FIFO_SYNC_WATERMARK_EN
    logic [4:0] n_peak, f_peak, o_peak;
`endif

    bit         m;
    logic       o_full, o_af, o_ov, o_empty, o_ae, o_uf;
    logic [7:0] o_dout;
    logic [4:0] o_count;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];
    logic [7:0] e;

    always #5 clk = ~clk;

    fifo_sync_flags #(.DSIZE(8), .ASIZE(4), .MODE("NORMAL"), .AF_LEVEL(14), .AE_LEVEL(1)) u_norm (
        .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
        .full(n_full), .almost_full(n_af), .overflow(n_ov), .dout(n_dout),
        .rd_en(rd_en), .empty(n_empty), .almost_empty(n_ae), .underflow(n_uf),
        .count(n_count)
`ifdef FIFO_SYNC_WATERMARK_EN
        , .peak(n_peak)
`endif
    );

    fifo_sync_flags #(.DSIZE(8), .ASIZE(4), .MODE("FWFT"), .AF_LEVEL(14), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
        .full(f_full), .almost_full(f_af), .overflow(f_ov), .dout(f_dout),
        .rd_en(rd_en), .empty(f_empty), .almost_empty(f_ae), .underflow(f_uf),
        .count(f_count)
`ifdef FIFO_SYNC_WATERMARK_EN
        , .peak(f_peak)
`endif
    );

    assign o_full  = m ? f_full  : n_full;
    assign o_af    = m ? f_af    : n_af;
    assign o_ov    = m ? f_ov    : n_ov;
    assign o_empty = m ? f_empty : n_empty;
    assign o_ae    = m ? f_ae    : n_ae;
    assign o_uf    = m ? f_uf    : n_uf;
    assign o_dout  = m ? f_dout  : n_dout;
    assign o_count = m ? f_count : n_count;
`ifdef FIFO_SYNC_WATERMARK_EN
    assign o_peak  = m ? f_peak  : n_peak;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s mode=%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(o_count), 0);
        chk({tag, "_empty"}, 32'(o_empty), 1);
        chk({tag, "_ae"},    32'(o_ae), 1);
        chk({tag, "_full"},  32'(o_full), 0);
        chk({tag, "_af"},    32'(o_af), 0);
        chk({tag, "_ov"},    32'(o_ov), 0);
        chk({tag, "_uf"},    32'(o_uf), 0);
        chk({tag, "_dout"},  32'(o_dout), 0);
    endtask

    // Pops the scoreboard and performs one read; leaves rd_en high for back-to-back use.
    task automatic rd_one();
        e = q.pop_front();
        if (m) begin
            chk("fwft_head", 32'(o_dout), 32'(e));
            chk("fwft_not_empty", 32'(o_empty), 0);
            rd_en = 1'b1;
            step();
        end else begin
            rd_en = 1'b1;
            step();
            chk("norm_dout", 32'(o_dout), 32'(e));
        end
    endtask

    task automatic run_mode();
        q.delete();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; din = 8'h00;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk_reset("reset");

        for (int i = 0; i < 16; i++) begin
            din = i[7:0]; wr_en = 1'b1;
            step();
            q.push_back(i[7:0]);
            if (i == 0)  chk("ae_at_1", 32'(o_ae), 1);
            if (i == 1)  chk("ae_at_2", 32'(o_ae), 0);
            if (i == 12) chk("af_at_13", 32'(o_af), 0);
            if (i == 13) chk("af_at_14", 32'(o_af), 1);
            if (i == 14) chk("full_at_15", 32'(o_full), 0);
        end
        wr_en = 1'b0;
        chk("full_at_16", 32'(o_full), 1);
        chk("count_16", 32'(o_count), 16);

        din = 8'hAA; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk("ov_set", 32'(o_ov), 1);
        chk("ov_count", 32'(o_count), 16);
        chk("ov_full", 32'(o_full), 1);
        step();
        chk("ov_sticky", 32'(o_ov), 1);

        din = 8'hBB; wr_en = 1'b1;
        rd_one();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("fullrw_count", 32'(o_count), 15);
        chk("fullrw_full", 32'(o_full), 0);
        chk("fullrw_ov", 32'(o_ov), 1);

        for (int i = 0; i < 15; i++) rd_one();
        rd_en = 1'b0;
        chk("drain_empty", 32'(o_empty), 1);
        chk("drain_count", 32'(o_count), 0);
        chk("drain_uf", 32'(o_uf), 0);

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("uf_set", 32'(o_uf), 1);
        chk("uf_count", 32'(o_count), 0);
        chk("uf_dout_hold", 32'(o_dout), 32'h0F);
        chk("uf_empty", 32'(o_empty), 1);
        chk("uf_ov_still", 32'(o_ov), 1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_uf", 32'(o_uf), 0);
        chk("flush_ov", 32'(o_ov), 0);
        chk("flush_dout", 32'(o_dout), 0);
        chk("flush_count", 32'(o_count), 0);
        chk("flush_empty", 32'(o_empty), 1);

        din = 8'h77; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("emptyrw_uf", 32'(o_uf), 1);
        chk("emptyrw_count", 32'(o_count), 1);
        chk("emptyrw_empty", 32'(o_empty), 32'(m));
        step();
        chk("emptyrw_empty2", 32'(o_empty), 0);
        if (m) chk("emptyrw_dout", 32'(o_dout), 32'h77);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush2_count", 32'(o_count), 0);
        chk("flush2_uf", 32'(o_uf), 0);

        din = 8'h5A; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk("w5a_empty_n", 32'(o_empty), 32'(m));
        step();
        chk("w5a_empty_n1", 32'(o_empty), 0);
        if (m) chk("w5a_dout_n1", 32'(o_dout), 32'h5A);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("r5a_empty", 32'(o_empty), 1);
        chk("r5a_ae", 32'(o_ae), 1);
        chk("r5a_dout", 32'(o_dout), 32'h5A);
        chk("r5a_count", 32'(o_count), 0);

        for (int i = 0; i < 8; i++) begin
            din = 8'h20 + i[7:0]; wr_en = 1'b1;
            step();
            q.push_back(din);
        end
        for (int k = 0; k < 40; k++) begin
            din = 8'h40 + k[7:0]; wr_en = 1'b1;
            rd_one();
            q.push_back(din);
            chk("wrap_count", 32'(o_count), 8);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) rd_one();
        rd_en = 1'b0;
        chk("wrap_empty", 32'(o_empty), 1);
        chk("wrap_count0", 32'(o_count), 0);

        for (int i = 0; i < 11; i++) begin
            din = 8'h60 + i[7:0]; wr_en = 1'b1;
            step();
            q.push_back(din);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) rd_one();
        rd_en = 1'b0;
        chk("wm_count3", 32'(o_count), 3);
        chk("wm_ae3", 32'(o_ae), 0);
        chk("wm_af3", 32'(o_af), 0);
`ifdef FIFO_SYNC_WATERMARK_EN
        chk("wm_peak11", 32'(o_peak), 11);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        q.delete();
        chk("wm_flush_count", 32'(o_count), 0);
        chk("wm_flush_empty", 32'(o_empty), 1);
`ifdef FIFO_SYNC_WATERMARK_EN
        chk("wm_flush_peak", 32'(o_peak), 0);
`endif

        for (int i = 0; i < 5; i++) begin
            din = 8'h90 + i[7:0]; wr_en = 1'b1;
            step();
        end
        #3;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step();
        wr_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk_reset("post_rst");
`ifdef FIFO_SYNC_WATERMARK_EN
        chk("post_rst_peak", 32'(o_peak), 0);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        m = 1'b0;
        run_mode();
        m = 1'b1;
        run_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
